alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Operand/program sequencer wrapped around the combinational `alu` stage. Drives `alu`'s packed operand bus, control code and enable; consumes `alu`'s packed `{B, C}` result.
- Holds operand registers A and B, plus a small program RAM of 3-bit ALU op codes.
- On each frame-rate step pulse (1-cycle VSYNC), issues one op and writes the result back as `{A, B} <= {B, C}`.
- With the default program, this produces a Fibonacci-style chain used by the display logic.

Parameters:
- `WIDTH`, 8, operand width in bits; must match the connected `alu`.
- `DEPTH`, 8, number of program entries; power of two, max 8.
- `PC_W`, 3, program-counter width, equal to log2(`DEPTH`).

Ports:
- `clk_i`  in  1  single system clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous active-high reset.
- `en_i`  in  1  step request; a 1-cycle pulse, normally VSYNC.
- `seed_we_i`  in  1  load operands from `seed_i`.
- `seed_i`  in  2*`WIDTH`  seed value `{A, B}`, A in the upper half.
- `prog_we_i`  in  1  program write strobe.
- `prog_addr_i`  in  `PC_W`  program write address.
- `prog_data_i`  in  3  op code to write.
- `len_i`  in  `PC_W`  index of the last program entry; the PC wraps after this entry.
- `AB_o`  out  2*`WIDTH`  `{A, B}` operand bus to `alu.AB_i`.
- `ctl_o`  out  3  op code to `alu.ctl_i`.
- `en_o`  out  1  enable to `alu.en_i`.
- `BC_i`  in  2*`WIDTH`  result `{B, C}` from `alu.BC_o`.
- `pc_o`  out  `PC_W`  current program counter.
- `busy_o`  out  1  high during the EXEC state.
- `wrap_o`  out  1  1-cycle pulse when the PC wraps to 0.
- `overrun_o`  out  1  sticky flag: an `en_i` pulse was dropped.

Behaviour:
- Reset values, asynchronous on `rst_i`:
  - A=0, B=0, pc=0.
  - Every program entry = 3'b100 (A+B).
  - `ctl_o`=0, `en_o`=0, `busy_o`=0, `wrap_o`=0, `overrun_o`=0.
  - State = IDLE.
- `AB_o` is always `{A, B}` (combinational from registers). `pc_o` = pc.
- FSM states: IDLE, EXEC.
  - IDLE --`en_i`--> EXEC. On the same edge: `ctl_o` <= prog[pc], `en_o` <= 1, `busy_o` <= 1.
  - EXEC --(unconditional, one cycle)--> IDLE. On the exiting edge:
    - `{A, B}` <= `BC_i`.
    - If pc >= `len_i`: pc <= 0 and `wrap_o` pulses for one cycle; otherwise pc <= pc+1.
    - `en_o` <= 0, `busy_o` <= 0. `ctl_o` holds its last value.
- Latency: `en_i` sampled at edge k → `en_o` high for the cycle between edges k and k+1 → operands updated at edge k+1. Minimum step spacing is 2 cycles.
- `en_i` while in EXEC: the request is dropped and `overrun_o` <= 1. The flag is sticky until `seed_we_i` or reset.
- `seed_we_i`:
  - `{A, B}` <= `seed_i`, pc <= 0, `overrun_o` <= 0.
  - If asserted in EXEC: the seed wins over the `BC_i` capture and the pc advance. `wrap_o` does not pulse. The FSM still returns to IDLE.
  - `seed_we_i` with `en_i` in IDLE: the seed loads and EXEC starts with op = prog[0] on seeded operands.
- `prog_we_i`:
  - Writes prog[`prog_addr_i`] at any time.
  - In EXEC, `ctl_o` is already registered, so the in-flight op is unaffected.
  - A write to prog[pc] on the same edge as an `en_i` in IDLE issues the OLD value.
- `len_i` is sampled live. If it is lowered below the current pc, the next step wraps (>= compare), so the pc never runs past `len_i`.
- `DEPTH` < 8: the upper bits of `prog_addr_i` are ignored, and the pc wraps at `DEPTH`-1 regardless of `len_i`.
- Arithmetic: none internal; all results come from `BC_i` modulo 2^`WIDTH` via `alu`.
- Reset asserted mid-EXEC: the FSM returns to IDLE immediately, `en_o` falls asynchronously, and no capture occurs.

Test Plan:
1. Fibonacci chain:
   - Stimulus: reset; seed {0,1}; `len_i`=7; 13 `en_i` pulses spaced 4 cycles.
   - Required response: after step n, B = F(n+1): 1,2,3,5,8,…. After step 13, A=233 and B=121 (377 mod 256). `wrap_o` pulses after steps 8.
2. Program / op codes:
   - Stimulus: write prog = {000,001,010,011,100,101,110,111}; seed {0x0F,0x3C}; 8 steps.
   - Required response: `ctl_o` sequence 0..7 with `en_o` high exactly one cycle each. B after each step equals the expected `alu` result on the current {A,B}, e.g. step 1 → {0x3C,0x00}.
3. Overrun:
   - Stimulus: `en_i` on two consecutive cycles.
   - Required response: one step executes, pc advances by 1, `overrun_o`=1. A following `seed_we_i` clears it to 0.
4. Seed vs capture:
   - Stimulus: `seed_we_i` with {0xAA,0x55} in the EXEC cycle.
   - Required response: A=0xAA, B=0x55, pc=0, no `wrap_o`, `busy_o` low next cycle.
5. Length shrink:
   - Stimulus: run to pc=5, then set `len_i`=2 and step.
   - Required response: pc=0, `wrap_o` pulses; subsequent steps cycle pc 0,1,2,0.
6. Async reset mid-EXEC:
   - Stimulus: assert `rst_i` mid-cycle while `en_o`=1.
   - Required response: `en_o`, `busy_o` go 0 without waiting for a clock edge; A=B=0; all program entries read back as 100.

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Operand/program sequencer wrapped around a combinational ALU
//                stage. Holds operands A and B plus a small program RAM of
//                3-bit op codes. Each step request issues the op at the
//                current program counter for one cycle, then writes back
//                {A, B} <= {B, C} from the ALU result bus.
//  Ports       : clk_i/rst_i          clock, asynchronous active-high reset
//                en_i                 step request (1-cycle pulse, VSYNC)
//                seed_we_i/seed_i     operand load {A, B}
//                prog_we_i/_addr_i/_data_i  program RAM write port
//                len_i                index of last program entry
//                AB_o/ctl_o/en_o      operand bus, op code, enable to ALU
//                BC_i                 {B, C} result from ALU
//                pc_o/busy_o/wrap_o/overrun_o  status
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PC_W  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 seed_we_i,
    input  logic [2*WIDTH-1:0]   seed_i,
    input  logic                 prog_we_i,
    input  logic [PC_W-1:0]      prog_addr_i,
    input  logic [2:0]           prog_data_i,
    input  logic [PC_W-1:0]      len_i,
    output logic [2*WIDTH-1:0]   AB_o,
    output logic [2:0]           ctl_o,
    output logic                 en_o,
    input  logic [2*WIDTH-1:0]   BC_i,
    output logic [PC_W-1:0]      pc_o,
    output logic                 busy_o,
    output logic                 wrap_o,
    output logic                 overrun_o
);

    localparam logic [0:0]      S_IDLE     = 1'b0;
    localparam logic [0:0]      S_EXEC     = 1'b1;
    localparam logic [2:0]      c_OP_RESET = 3'b100;
    localparam logic [PC_W-1:0] c_PC_LAST  = PC_W'(DEPTH - 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PC_W-1:0]  r_pc;
    logic [2:0]       r_prog [DEPTH];
    logic [2:0]       r_ctl;
    logic             r_en;
    logic             r_busy;
    logic             r_wrap;
    logic             r_ovr;

    logic [PC_W-1:0]  w_issue_pc;
    logic             w_last;

    // A seed arriving together with a step request restarts the program,
    // so the issued op must come from entry 0 rather than the old pc.
    assign w_issue_pc = seed_we_i ? '0 : r_pc;

    // >= rather than == so that lowering len_i below the pc still wraps on
    // the next step; the all-ones pc term bounds the pc when DEPTH < 8.
    assign w_last = (r_pc >= len_i) || (r_pc == c_PC_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_pc    <= '0;
            r_ctl   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
            r_ovr   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_prog[i] <= c_OP_RESET;
            end
        end else begin
            r_wrap <= 1'b0;

            // The issue path below reads r_prog before this write lands,
            // so a same-edge write to prog[pc] issues the old op.
            if (prog_we_i) begin
                r_prog[prog_addr_i] <= prog_data_i;
            end

            case (r_state)
                S_IDLE: begin
                    if (en_i) begin
                        r_state <= S_EXEC;
                        r_ctl   <= r_prog[w_issue_pc];
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    if (en_i) begin
                        r_ovr <= 1'b1;
                    end
                    if (!seed_we_i) begin
                        {r_a, r_b} <= BC_i;
                        if (w_last) begin
                            r_pc   <= '0;
                            r_wrap <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Seed has priority over the result capture and pc advance.
            if (seed_we_i) begin
                {r_a, r_b} <= seed_i;
                r_pc       <= '0;
                r_ovr      <= 1'b0;
            end
        end
    end

    assign AB_o      = {r_a, r_b};
    assign ctl_o     = r_ctl;
    assign en_o      = r_en;
    assign pc_o      = r_pc;
    assign busy_o    = r_busy;
    assign wrap_o    = r_wrap;
    assign overrun_o = r_ovr;

endmodule
`default_nettype wire
